hash_rd_seq: RTL
================

Name: hash_rd_seq

Overview:
Read-out sequencer for the 384-bit hash result. On a host read command it walks the 12-word result window of the read mux via rd_addr (word 0 first) and captures each 32-bit word. It then serialises each word MSB-byte-first onto a byte-wide valid/ready stream feeding the SPI transmit path. It also tracks whether a valid result is available and flags illegal or interrupted read-outs.

Parameters:
NUM_WORDS, 12, number of 32-bit words per read-out; legal range 1..16, set by the 4-bit address.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
hash_done  input  1  single-cycle pulse: hash result valid on the read mux.
hash_clr  input  1  single-cycle pulse: result invalidated because a new hash is starting.
start  input  1  single-cycle pulse from the SPI command decoder: begin read-out.
abort  input  1  single-cycle pulse: cancel read-out.
rd_d  input  32  word returned by the combinational read mux for rd_addr.
rd_addr  output  4  word index driven to the read mux.
tx_data  output  8  byte to the SPI transmitter.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  transmitter accepts the byte this cycle.
busy  output  1  read-out in progress.
done  output  1  single-cycle pulse: read-out completed.
err  output  1  single-cycle pulse: start rejected or read-out interrupted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; result_valid = 0.
  - rd_addr = 0, tx_data = 0, tx_valid = 0, busy = 0, done = 0, err = 0.
  - Word, byte and shift registers cleared.
- All outputs are registered.
- result_valid flag:
  - Set by hash_done.
  - Cleared by hash_clr.
  - hash_clr wins when both pulse in the same cycle.
- States:
  - IDLE:
    - rd_addr = 0.
    - start with result_valid = 1: word_cnt = 0, go to LOAD.
    - start with result_valid = 0: err pulse, stay IDLE.
    - start and hash_done in the same cycle: rejected (uses the pre-update flag).
  - LOAD:
    - rd_addr = word_cnt; the read mux is combinational.
    - rd_d is captured into shreg in this cycle; byte_cnt = 0; go to SEND.
  - SEND:
    - tx_valid = 1, tx_data = shreg[31:24].
    - On tx_valid && tx_ready: shreg shifts left by 8 and byte_cnt increments.
    - On the accept with byte_cnt = 3: go to DONE if word_cnt = NUM_WORDS-1; otherwise word_cnt increments and go to LOAD.
    - tx_data stays stable while tx_valid && !tx_ready.
  - DONE:
    - done = 1 for one cycle, tx_valid = 0, then go to IDLE.
    - result_valid stays set, so repeat read-outs are allowed.
- busy = 1 in LOAD, SEND and DONE.
- Latency with tx_ready held at 1:
  - start sampled in cycle 0 → LOAD in cycle 1, first tx_valid in cycle 2.
  - Each word takes 5 cycles (1 LOAD + 4 bytes).
  - Last byte accepted in cycle 60, done in cycle 61, IDLE in cycle 62.
- Abort and interruption:
  - abort while busy: next cycle state = IDLE, tx_valid = 0, no done, no err. This is the only case where tx_valid may drop without a handshake.
  - abort in IDLE: ignored.
  - hash_clr while busy: behaves as abort, plus an err pulse.
  - abort and hash_clr in the same cycle: err pulse.
- start while busy: ignored, no err.
- Reset mid-read-out: immediate return to reset values, with no done and no err pulse.
- rd_addr never exceeds NUM_WORDS-1.

Test Plan:
1. Basic read-out, tx_ready = 1, result = words 0x00010203 + 0x04040404*k:
   - hash_done, then start → 48 bytes in order 00,01,02,03,04,05,…; done in cycle 61; busy low in cycle 62.
   - rd_addr sequences 0..11.
2. Backpressure, tx_ready toggled 1,0,0,1,… pseudo-randomly:
   - Byte order identical to scenario 1.
   - tx_data holds its value during every stall.
   - done pulses exactly once, 1 cycle after the 48th accept.
3. start with no result (after reset, or after hash_clr) → err pulse the next cycle, busy stays 0, tx_valid stays 0.
4. abort after the 10th byte accept → tx_valid = 0 and busy = 0 the next cycle; no done, no err. A following start restarts from byte 0 of word 0.
5. hash_clr during word 5 → err pulse, return to IDLE. The next start errs until a new hash_done arrives.
6. rst_n asserted low mid-SEND (asynchronously, between clock edges) → all outputs 0 immediately. After release, start errs because result_valid is cleared.

Source files
------------

// File: rtl/hash_rd_seq.sv
// hash_rd_seq: reads the hash result word by word from a combinational read
// mux and streams it out MSB byte first on a byte-wide valid/ready interface.
// Tracks whether a result is available and flags rejected or interrupted
// read-outs with a single-cycle err pulse.
module hash_rd_seq #(
  parameter int NUM_WORDS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hash_done,
  input  logic        hash_clr,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] rd_d,
  output logic [3:0]  rd_addr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  state_t      state_q, state_d;
  logic        result_valid_q, result_valid_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Result-available flag; an invalidation beats a completion in the same cycle.
  always_comb begin
    result_valid_d = result_valid_q;
    if (hash_clr) begin
      result_valid_d = 1'b0;
    end else if (hash_done) begin
      result_valid_d = 1'b1;
    end
  end

  // Sequencer next state: word/byte walk, capture and shift; abort/clear override.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (result_valid_q) begin
            word_cnt_d = 4'd0;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        shreg_d    = rd_d;
        byte_cnt_d = 2'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          shreg_d    = {shreg_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_cnt_q == LAST_WORD) begin
              state_d = S_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
              state_d    = S_LOAD;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_q != S_IDLE) && (abort || hash_clr)) begin
      state_d = S_IDLE;
      err_d   = hash_clr;
    end
  end

  // Registered outputs are derived from the state being entered so they line up with it.
  always_comb begin
    rd_addr_d  = (state_d == S_IDLE) ? 4'd0 : word_cnt_d;
    tx_valid_d = (state_d == S_SEND);
    tx_data_d  = (state_d == S_SEND) ? shreg_d[31:24] : 8'h00;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      result_valid_q <= 1'b0;
      word_cnt_q     <= 4'd0;
      byte_cnt_q     <= 2'd0;
      shreg_q        <= 32'h0;
      rd_addr_q      <= 4'd0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_valid_q <= result_valid_d;
      word_cnt_q     <= word_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      shreg_q        <= shreg_d;
      rd_addr_q      <= rd_addr_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
